// File: rtl/jtdsp16_rbus_ctrl_if.sv
// rtl/jtdsp16_rbus_ctrl_if.sv - core, host and register-file signals of the R-bus controller
// Optional error outputs are present when JTDSP16_RBUS_ERR_EN is defined.
interface jtdsp16_rbus_ctrl_if;
  logic        core_req;
  logic        core_we;
  logic [5:0]  core_addr;
  logic [15:0] core_wdata;
  logic        core_stall;
  logic        core_rvalid;
  logic [15:0] core_rdata;
  logic        host_req;
  logic        host_we;
  logic [5:0]  host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic [15:0] rmux;
  logic [2:0]  rsel;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        yaau_we;
  logic        xaau_we;
  logic        dau_we;
  logic        if_we;
`ifdef JTDSP16_RBUS_ERR_EN
  logic        rbus_err;
  logic [7:0]  rbus_errcnt;
`endif

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata, rmux,
    output core_stall, core_rvalid, core_rdata, host_ack, host_rdata,
    output rsel, reg_addr, reg_wdata, yaau_we, xaau_we, dau_we, if_we
`ifdef JTDSP16_RBUS_ERR_EN
    , output rbus_err, rbus_errcnt
`endif
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata, rmux,
    input  core_stall, core_rvalid, core_rdata, host_ack, host_rdata,
    input  rsel, reg_addr, reg_wdata, yaau_we, xaau_we, dau_we, if_we
`ifdef JTDSP16_RBUS_ERR_EN
    , input rbus_err, rbus_errcnt
`endif
  );
endinterface

// File: rtl/jtdsp16_rbus_ctrl.sv
// rtl/jtdsp16_rbus_ctrl.sv - R-bus sequencer and core/host arbiter with host anti-starvation
// Optional sticky error flag and counter when JTDSP16_RBUS_ERR_EN is defined.
module jtdsp16_rbus_ctrl #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  jtdsp16_rbus_ctrl_if.slave bus
);
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE = 2'd0, CORE_CAP = 2'd1, HOST_CAP = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [7:0]  starve;
  logic [3:0]  strobe, strobe_nxt;
  logic        hreq, forced, core_gnt, host_gnt, gnt, g_we;
  logic [5:0]  g_addr;
  logic [15:0] g_wdata, cap_data;

  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (cen) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt && !g_we) state_nxt = core_gnt ? CORE_CAP : HOST_CAP;
      default: state_nxt = IDLE;
    endcase
  end

  // A host request whose ack is already showing is complete and must not be re-granted
  assign hreq = bus.host_req & ~bus.host_ack;

  always_comb begin
    forced   = (state == IDLE) && hreq && (starve == SMAX);
    core_gnt = (state == IDLE) && bus.core_req && !forced;
    host_gnt = (state == IDLE) && hreq && !core_gnt;
    gnt      = core_gnt || host_gnt;
    g_we     = core_gnt ? bus.core_we    : bus.host_we;
    g_addr   = core_gnt ? bus.core_addr  : bus.host_addr;
    g_wdata  = core_gnt ? bus.core_wdata : bus.host_wdata;
    strobe_nxt = 4'd0;
    if (gnt && g_we && !g_addr[5]) strobe_nxt[g_addr[4:3]] = 1'b1;
    cap_data = bus.reg_addr[5] ? 16'd0 : bus.rmux;
    bus.core_stall = bus.core_req && !core_gnt;
  end

  assign {bus.if_we, bus.dau_we, bus.xaau_we, bus.yaau_we} = strobe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe          <= 4'd0;
      starve          <= 8'd0;
      bus.rsel        <= 3'd0;
      bus.reg_addr    <= 6'd0;
      bus.reg_wdata   <= 16'd0;
      bus.core_rdata  <= 16'd0;
      bus.core_rvalid <= 1'b0;
      bus.host_rdata  <= 16'd0;
      bus.host_ack    <= 1'b0;
    end else if (cen) begin
      strobe          <= strobe_nxt;
      bus.core_rvalid <= (state == CORE_CAP);
      bus.host_ack    <= (state == HOST_CAP) || (host_gnt && g_we);
      if (gnt) begin
        bus.reg_addr <= g_addr;
        if (g_we) bus.reg_wdata <= g_wdata;
        else      bus.rsel      <= {1'b0, g_addr[4:3]};
      end
      if (state == CORE_CAP) bus.core_rdata <= cap_data;
      if (state == HOST_CAP) bus.host_rdata <= cap_data;
      if (host_gnt || !hreq)  starve <= 8'd0;
      else if (starve != SMAX) starve <= starve + 8'd1;
    end
  end

`ifdef JTDSP16_RBUS_ERR_EN
  logic err_clr, err_hit;
  assign err_clr = host_gnt && bus.host_we && (bus.host_addr == 6'd63);
  assign err_hit = gnt && g_addr[5] && !err_clr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.rbus_err    <= 1'b0;
      bus.rbus_errcnt <= 8'd0;
    end else if (cen) begin
      if (err_clr) begin
        bus.rbus_err    <= 1'b0;
        bus.rbus_errcnt <= 8'd0;
      end else if (err_hit) begin
        bus.rbus_err <= 1'b1;
        if (bus.rbus_errcnt != 8'hff) bus.rbus_errcnt <= bus.rbus_errcnt + 8'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_jtdsp16_rbus_ctrl.sv
// tb/tb_jtdsp16_rbus_ctrl.sv - directed and randomized bench for jtdsp16_rbus_ctrl with a behavioural model
// Error-output checks are compiled in when JTDSP16_RBUS_ERR_EN is defined.
module tb_jtdsp16_rbus_ctrl;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic rst_n, cen;
  logic chk_en = 1'b0;
  int   n_chk = 0, n_fail = 0;

  jtdsp16_rbus_ctrl_if bus ();

  jtdsp16_rbus_ctrl #(.STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 4951 + 16'h0ace);
  endfunction

  // Register-file emulation feeding rmux from the DUT's own strobes
  logic [15:0] tb_mem [0:31];
  logic [3:0]  stb;
  assign stb      = {bus.if_we, bus.dau_we, bus.xaau_we, bus.yaau_we};
  assign bus.rmux = tb_mem[{bus.rsel[1:0], bus.reg_addr[2:0]}];

  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 32; i++) tb_mem[i] <= init_val(i);
    else if (cen) for (int u = 0; u < 4; u++)
      if (stb[u]) tb_mem[u * 8 + int'(bus.reg_addr[2:0])] <= bus.reg_wdata;
  end

  // Behavioural model: a pending capture record plus expected output values
  int          m_cap, m_starve, m_cnt;
  logic [5:0]  m_cap_addr, m_addr;
  logic [2:0]  m_rsel;
  logic [15:0] m_wdata, m_crd, m_hrd;
  logic [3:0]  m_stb;
  logic        m_rv, m_ack, m_err;
  logic [15:0] m_mem [0:31];

  always @(posedge clk) begin : model
    logic busy, hreq, forced, cg, hg, we;
    logic [5:0]  a;
    logic [15:0] d;
    if (!rst_n) begin
      m_cap = 0; m_starve = 0; m_cnt = 0; m_cap_addr = 0; m_addr = 0; m_rsel = 0;
      m_wdata = 0; m_crd = 0; m_hrd = 0; m_stb = 0; m_rv = 0; m_ack = 0; m_err = 0;
      for (int i = 0; i < 32; i++) m_mem[i] = init_val(i);
    end else if (cen) begin
      busy   = (m_cap != 0);
      hreq   = bus.host_req && !m_ack;
      forced = !busy && hreq && (m_starve == SMAX);
      cg     = !busy && bus.core_req && !forced;
      hg     = !busy && !cg && hreq;
      m_stb = 0; m_rv = 0; m_ack = 0;
      if (busy) begin
        d = (m_cap_addr >= 32) ? 16'd0 : m_mem[m_cap_addr[4:0]];
        if (m_cap == 1) begin m_crd = d; m_rv = 1; end
        else begin m_hrd = d; m_ack = 1; end
        m_cap = 0;
      end
      if (cg || hg) begin
        we = cg ? bus.core_we : bus.host_we;
        a  = cg ? bus.core_addr : bus.host_addr;
        d  = cg ? bus.core_wdata : bus.host_wdata;
        m_addr = a;
        if (we) begin
          m_wdata = d;
          if (a < 32) begin m_stb[a / 8] = 1'b1; m_mem[a[4:0]] = d; end
          if (hg) m_ack = 1;
        end else begin
          m_rsel = 3'((a / 8) % 4);
          m_cap = cg ? 1 : 2;
          m_cap_addr = a;
        end
        if (a >= 32) begin
          if (hg && we && a == 63) begin m_err = 0; m_cnt = 0; end
          else begin m_err = 1; if (m_cnt < 255) m_cnt++; end
        end
      end
      if (hg || !hreq) m_starve = 0;
      else if (m_starve < SMAX) m_starve++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("core_stall", 32'(bus.core_stall),
        32'(bus.core_req && (m_cap != 0 || (bus.host_req && !m_ack && m_starve == SMAX))));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(m_rv));
    chk("core_rdata",  32'(bus.core_rdata),  32'(m_crd));
    chk("host_ack",    32'(bus.host_ack),    32'(m_ack));
    chk("host_rdata",  32'(bus.host_rdata),  32'(m_hrd));
    chk("rsel",        32'(bus.rsel),        32'(m_rsel));
    chk("reg_addr",    32'(bus.reg_addr),    32'(m_addr));
    chk("reg_wdata",   32'(bus.reg_wdata),   32'(m_wdata));
    chk("strobes",     32'(stb),             32'(m_stb));
`ifdef JTDSP16_RBUS_ERR_EN
    chk("rbus_err",    32'(bus.rbus_err),    32'(m_err));
    chk("rbus_errcnt", 32'(bus.rbus_errcnt), 32'(m_cnt));
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic core_go(input logic we, input logic [5:0] a, input logic [15:0] d);
    int n = 0;
    bus.core_req = 1; bus.core_we = we; bus.core_addr = a; bus.core_wdata = d;
    #1;
    while (bus.core_stall && n < 50) begin step(); n++; end
    chk("core_grant_timeout", 32'(n < 50), 1);
    step();
    bus.core_req = 0;
  endtask

  task automatic host_go(input logic we, input logic [5:0] a, input logic [15:0] d);
    int n = 0;
    bus.host_req = 1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    step();
    while (!bus.host_ack && n < 50) begin step(); n++; end
    chk("host_ack_timeout", 32'(n < 50), 1);
    bus.host_req = 0;
  endtask

  function automatic logic [5:0] rnd_addr();
    return ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] alist [4];
    logic g;
    alist[0] = 6'd3; alist[1] = 6'd9; alist[2] = 6'd20; alist[3] = 6'd28;
    rst_n = 0; cen = 1;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    step(); chk_en = 1; step(); step();
    chk("rst_rsel", 32'(bus.rsel), 0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 0);
    chk("rst_reg_wdata", 32'(bus.reg_wdata), 0);
    chk("rst_core_rdata", 32'(bus.core_rdata), 0);
    chk("rst_host_rdata", 32'(bus.host_rdata), 0);
    chk("rst_pulses", 32'({stb, bus.core_rvalid, bus.host_ack}), 0);
    rst_n = 1; step();

    // Core write then read of the same DAU register
    core_go(1, 6'd17, 16'h1234);
    chk("wr17_strobes", 32'(stb), 32'b0100);
    chk("wr17_reg_addr", 32'(bus.reg_addr), 17);
    chk("wr17_reg_wdata", 32'(bus.reg_wdata), 32'h1234);
    core_go(0, 6'd17, 16'h0);
    chk("rd17_rsel", 32'(bus.rsel), 2);
    chk("rd17_early_rvalid", 32'(bus.core_rvalid), 0);
    step();
    chk("rd17_rvalid", 32'(bus.core_rvalid), 1);
    chk("rd17_rdata", 32'(bus.core_rdata), 32'h1234);

    // Unit decode
    for (int i = 0; i < 4; i++) begin
      core_go(1, alist[i], 16'hC000 | 16'(alist[i]));
      chk("dec_strobe", 32'(stb), 32'(1 << i));
      core_go(0, alist[i], 16'h0);
      chk("dec_rsel", 32'(bus.rsel), 32'(i));
      step();
      chk("dec_rdata", 32'(bus.core_rdata), 32'hC000 | 32'(alist[i]));
    end

    // Contention: host forced in after the starve counter saturates
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 6'd8;
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 6'd5;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("cont_no_ack", 32'(bus.host_ack), 0);
    end
    chk("cont_forced_stall", 32'(bus.core_stall), 1);
    step(); step();
    chk("cont_host_ack", 32'(bus.host_ack), 1);
    chk("cont_host_rdata", 32'(bus.host_rdata), 32'(init_val(8)));
    bus.host_req = 0;
    #1;
    chk("cont_core_resume", 32'(bus.core_stall), 0);
    step(); bus.core_req = 0; step(); step();

    // Invalid address accesses from the host
    host_go(0, 6'd40, 16'h0);
    chk("inv_rd_data", 32'(bus.host_rdata), 0);
    step();
    host_go(1, 6'd40, 16'hBEEF);
    chk("inv_wr_nostrobe", 32'(stb), 0);
    step();
`ifdef JTDSP16_RBUS_ERR_EN
    chk("err_set", 32'(bus.rbus_err), 1);
    chk("errcnt_two", 32'(bus.rbus_errcnt), 2);
    host_go(1, 6'd63, 16'h0);
    chk("err_clr", 32'(bus.rbus_err), 0);
    chk("errcnt_clr", 32'(bus.rbus_errcnt), 0);
    step();
`endif

    // cen gating during a core read
    core_go(0, 6'd20, 16'h0);
    cen = 0; step();
    chk("cen_no_rvalid", 32'(bus.core_rvalid), 0);
    chk("cen_rsel", 32'(bus.rsel), 2);
    cen = 1; step();
    chk("cen_rvalid", 32'(bus.core_rvalid), 1);
    chk("cen_rdata", 32'(bus.core_rdata), 32'hC014);
    cen = 0; step();
    chk("cen_hold1", 32'(bus.core_rvalid), 1);
    step();
    chk("cen_hold2", 32'(bus.core_rvalid), 1);
    cen = 1; step();
    chk("cen_pulse_end", 32'(bus.core_rvalid), 0);

    // Reset while a core read is in its capture cycle
    core_go(0, 6'd9, 16'h0);
    rst_n = 0; step();
    chk("rstmid_rvalid", 32'(bus.core_rvalid), 0);
    chk("rstmid_outs", 32'({bus.rsel, bus.reg_addr, bus.core_rdata, bus.host_rdata}), 0);
    rst_n = 1;
    bus.core_req = 1; bus.core_we = 0; bus.core_addr = 6'd9;
    #1;
    chk("rstmid_regrant", 32'(bus.core_stall), 0);
    step(); bus.core_req = 0;
    chk("rstmid_rsel", 32'(bus.rsel), 1);
    step();
    chk("rstmid_rdata", 32'({bus.core_rvalid, bus.core_rdata}), 32'({1'b1, init_val(9)}));

    // Randomized traffic with random clock enable
    for (int i = 0; i < 3000; i++) begin
      cen = ($urandom_range(0, 3) != 0);
      if (!bus.core_req && $urandom_range(0, 2) == 0) begin
        bus.core_req = 1; bus.core_we = 1'($urandom_range(0, 1));
        bus.core_addr = rnd_addr(); bus.core_wdata = 16'($urandom);
      end
      if (!bus.host_req && !bus.host_ack && $urandom_range(0, 3) == 0) begin
        bus.host_req = 1; bus.host_we = 1'($urandom_range(0, 1));
        bus.host_addr = rnd_addr(); bus.host_wdata = 16'($urandom);
      end
      #1;
      g = cen && bus.core_req && !bus.core_stall;
      step();
      if (g) bus.core_req = 0;
      if (bus.host_req && bus.host_ack) bus.host_req = 0;
    end
    cen = 1; bus.core_req = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.host_ack) bus.host_req = 0;
    end
    chk("drain_idle", 32'({bus.host_req, bus.core_stall}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtdsp16_rbus_ctrl.md
Name: jtdsp16_rbus_ctrl

Overview:
- Sequences the shared internal register (R) bus and feeds the 4-way register read mux: drives the 3-bit source select and the register address, and captures the mux output.
- Also drives the write strobes for the YAAU, XAAU, DAU and interface register files.
- Arbitrates the bus between two requesters: the core instruction decoder (priority) and a host/debug port (req/ack handshake).
- Includes anti-starvation for the host requester.

Parameters:
- STARVE_MAX, 8: cen cycles the host may wait before one forced host slot; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cen  in  1  clock enable; all state advances only when cen=1
- core_req  in  1  core bus request (level)
- core_we  in  1  1=write, 0=read
- core_addr  in  6  R-field register address
- core_wdata  in  16  core write data
- core_stall  out  1  combinational; core_req=1 and not granted this cycle
- core_rvalid  out  1  one-cen-cycle pulse: core_rdata valid
- core_rdata  out  16  core read data
- host_req  in  1  host request; held until host_ack
- host_we  in  1  1=write
- host_addr  in  6  register address
- host_wdata  in  16  host write data
- host_ack  out  1  one-cen-cycle completion pulse
- host_rdata  out  16  host read data, valid with host_ack
- rmux  in  16  read mux output, combinational from reg_addr/rsel
- rsel  out  3  mux select: 0 YAAU, 1 XAAU, 2 DAU, 3 IF
- reg_addr  out  6  address to register files
- reg_wdata  out  16  write data to register files
- yaau_we, xaau_we, dau_we, if_we  out  1 each  write strobes, one cen cycle

Behaviour:
- Address decode (on the 6-bit address):
  - addr[5]=1 is invalid.
  - Otherwise addr[4:3] gives the unit: 0 YAAU (0-7), 1 XAAU (8-15), 2 DAU (16-23), 3 IF (24-31).
- Reset (rst_n=0 at a clk edge, regardless of cen):
  - state IDLE; starve counter 0.
  - rsel, reg_addr, reg_wdata, core_rdata, host_rdata = 0.
  - All strobes, core_rvalid and host_ack = 0.
  - An in-flight read is discarded with no rvalid/ack.
- State machine (transitions on cen=1 edges): IDLE, CORE_CAP, HOST_CAP.
- IDLE grant:
  - core_req=1 and no forced host slot: core granted.
  - Else host_req=1: host granted.
  - Forced host slot: host_req=1 and starve counter = STARVE_MAX; core_stall=1 that cycle.
- Grant of a write:
  - Next cycle: reg_addr, reg_wdata registered and exactly one unit strobe high for one cen cycle.
  - State stays IDLE.
  - Host write: host_ack pulses in the same cycle as the strobe.
  - Invalid address: no strobe; ack still given to the host.
- Grant of a read:
  - reg_addr and rsel registered; state goes to CORE_CAP or HOST_CAP.
  - In the capture state: rmux latched into core_rdata (core_rvalid=1) or host_rdata (host_ack=1); state returns to IDLE.
  - Invalid address: returns 0.
  - Read latency is 2 cen cycles from acceptance to valid data.
- No new grant in CORE_CAP/HOST_CAP; core_stall=1 there if core_req=1.
- Write-to-read hazard: a write followed by a read of the same register is ordered. The read's address cycle follows the strobe cycle, so it returns the new value.
- Starve counter:
  - Increments each cen cycle host_req=1 and the host is not granted; saturates at STARVE_MAX.
  - Clears on host grant or host_req=0.
- cen=0: all outputs hold; pulses extend over the cen-low cycles until the next cen=1 edge. core_stall still evaluates combinationally.
- Simultaneous core and host requests with counter < STARVE_MAX: core wins.
- Host must keep host_req/addr/we/wdata stable until host_ack. Dropping host_req before ack is not supported.

Optional Feature:
- Macro JTDSP16_RBUS_ERR_EN.
- Defined: adds outputs rbus_err (1 bit, sticky) and rbus_errcnt (8 bits, saturating).
  - Both set/increment on any granted access with addr[5]=1.
  - Cleared by reset and by a host write to address 63. That write is itself not counted.
- Undefined: ports absent; invalid accesses silently return 0 or are dropped.

Test Plan:
- Core write then read: core write addr 17 data 0x1234; next core read addr 17 -> dau_we 1 cycle with reg_addr=17, reg_wdata=0x1234; then rsel=2, core_rvalid 2 cycles after read grant, core_rdata = rmux (model returns 0x1234).
- Unit decode: core reads of addr 3, 9, 20, 28 -> rsel 0, 1, 2, 3 respectively; a write to each addr asserts only the matching strobe.
- Contention: core_req held for 20 cycles with reads, host read of addr 8, STARVE_MAX=8 -> host granted when counter=8 with core_stall=1 that cycle; host_ack and host_rdata=rmux two cycles later; core resumes afterwards.
- Invalid address: host read addr 40 -> host_ack with host_rdata=0; host write addr 40 -> no strobe, ack given. With JTDSP16_RBUS_ERR_EN: rbus_err=1, rbus_errcnt=2; host write addr 63 clears both.
- cen gating: cen toggling 1/0 during a core read -> core_rvalid asserted only after the 2nd cen=1 edge and held through cen=0; all state is frozen while cen=0.
- Reset mid-read: rst_n=0 in CORE_CAP -> no core_rvalid, all outputs 0, state IDLE; the next core_req is granted immediately.
